com_edge_detect_mc: RTL

COM_EDGE_DETECT_MC -- requirements
Module: com_edge_detect_mc

---
 rtl/com_edge_detect_mc_if.sv | 23 ++
 rtl/com_edge_detect_mc.sv | 79 +++++++
 2 files changed

// File: rtl/com_edge_detect_mc_if.sv
// com_edge_detect_mc_if: per-channel level/mode/clear inputs and filtered level, pulse and flag outputs.
interface com_edge_detect_mc_if #(
  parameter int unsigned CH     = 4,
  parameter int unsigned FILT_W = 4
) ();
  logic [CH-1:0]     level_in;
  logic [FILT_W-1:0] filt_cyc;
  logic [2*CH-1:0]   mode_sel;
  logic [CH-1:0]     flag_clr;
  logic [CH-1:0]     level_filt;
  logic [CH-1:0]     pulse_out;
  logic [CH-1:0]     sticky_flag;

  modport master (
    output level_in, filt_cyc, mode_sel, flag_clr,
    input  level_filt, pulse_out, sticky_flag
  );

  modport slave (
    input  level_in, filt_cyc, mode_sel, flag_clr,
    output level_filt, pulse_out, sticky_flag
  );
endinterface

// File: rtl/com_edge_detect_mc.sv
// com_edge_detect_mc: per-channel glitch filter with edge pulse and sticky event flag.
// Define COM_EDGE_DETECT_SYNC_EN to insert a 2-flop synchronizer per channel ahead of the filter.
module com_edge_detect_mc #(
  parameter int unsigned CH     = 4,
  parameter int unsigned FILT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  com_edge_detect_mc_if.slave bus
);

  logic [CH-1:0]     filt_in;
  logic [CH-1:0]     level_filt_q, level_filt_d;
  logic [CH-1:0]     pulse_q, pulse_d;
  logic [CH-1:0]     sticky_q, sticky_d;
  logic [FILT_W-1:0] cnt_q [CH];
  logic [FILT_W-1:0] cnt_d [CH];

`ifdef COM_EDGE_DETECT_SYNC_EN
  logic [CH-1:0] sync1_q, sync1_d;
  logic [CH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.level_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign filt_in = sync2_q;
`else
  assign filt_in = bus.level_in;
`endif

  // A toggle needs filt_cyc+1 consecutive differing samples; cnt saturates at filt_cyc so it never wraps.
  always_comb begin
    level_filt_d = level_filt_q;
    pulse_d      = '0;
    cnt_d        = '{default: '0};
    for (int i = 0; i < int'(CH); i++) begin
      if (filt_in[i] != level_filt_q[i]) begin
        if (cnt_q[i] < bus.filt_cyc) begin
          cnt_d[i] = cnt_q[i] + FILT_W'(1);
        end else begin
          level_filt_d[i] = filt_in[i];
          pulse_d[i]      = filt_in[i] ? bus.mode_sel[2*i] : bus.mode_sel[2*i+1];
        end
      end
    end
    sticky_d = pulse_d | (sticky_q & ~bus.flag_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_filt_q <= '0;
      pulse_q      <= '0;
      sticky_q     <= '0;
      cnt_q        <= '{default: '0};
    end else begin
      level_filt_q <= level_filt_d;
      pulse_q      <= pulse_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.level_filt  = level_filt_q;
  assign bus.pulse_out   = pulse_q;
  assign bus.sticky_flag = sticky_q;

endmodule
